// File: rtl/param_reg_file.sv
// Parametrised ALU register file: masked multi-register writes, half-word loads, sticky wrap flags.
// Build option PARAM_REG_FILE_SATURATE_EN makes inc/dec saturate instead of wrapping.

module param_reg_cell #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             writeEn,
  input  logic [1:0]       funSel,
  input  logic [1:0]       halfSel,
  input  logic [WIDTH-1:0] loadData,
  output logic [WIDTH-1:0] value,
  output logic             wrap
);
  localparam int HW = WIDTH / 2;

  logic atZero, atOnes;
  assign atZero = (value == '0);
  assign atOnes = (value == '1);

  always_ff @(posedge CLK) begin
    if (RST) begin
      value <= '0;
      wrap  <= 1'b0;
    end else if (writeEn) begin
      case (funSel)
        2'b00: begin
          value <= '0;
          wrap  <= 1'b0;
        end
        2'b01: begin
          case (halfSel)
            2'b01:   value[HW-1:0]     <= loadData[HW-1:0];
            2'b10:   value[WIDTH-1:HW] <= loadData[HW-1:0];
            default: value             <= loadData;
          endcase
        end
        2'b10: begin
          if (atZero) wrap <= 1'b1;
`ifdef PARAM_REG_FILE_SATURATE_EN
          if (!atZero) value <= value - 1'b1;
`else
          value <= value - 1'b1;
`endif
        end
        default: begin
          if (atOnes) wrap <= 1'b1;
`ifdef PARAM_REG_FILE_SATURATE_EN
          if (!atOnes) value <= value + 1'b1;
`else
          value <= value + 1'b1;
`endif
        end
      endcase
    end
  end
endmodule

module param_reg_file #(
  parameter int N_REGS = 4,
  parameter int WIDTH  = 8,
  localparam int SEL_W = $clog2(N_REGS)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [N_REGS-1:0] RegSel,
  input  logic [1:0]        FunSel,
  input  logic [1:0]        HalfSel,
  input  logic [WIDTH-1:0]  I,
  input  logic [SEL_W-1:0]  OutASel,
  input  logic [SEL_W-1:0]  OutBSel,
  output logic [WIDTH-1:0]  OutA,
  output logic [WIDTH-1:0]  OutB,
  output logic [N_REGS-1:0] WrapFlag
);
  logic [N_REGS-1:0][WIDTH-1:0] regs;

  genvar g;
  generate
    for (g = 0; g < N_REGS; g++) begin : gCell
      param_reg_cell #(.WIDTH(WIDTH)) uCell (
        .CLK      (CLK),
        .RST      (RST),
        .writeEn  (RegSel[g]),
        .funSel   (FunSel),
        .halfSel  (HalfSel),
        .loadData (I),
        .value    (regs[g]),
        .wrap     (WrapFlag[g])
      );
    end
  endgenerate

  // Selects that match no register fall through to zero.
  always_comb begin
    OutA = '0;
    OutB = '0;
    for (int i = 0; i < N_REGS; i++) begin
      if (OutASel == SEL_W'(i)) OutA = regs[i];
      if (OutBSel == SEL_W'(i)) OutB = regs[i];
    end
  end
endmodule
